chimp_game_ctrl: RTL and testbench
==================================

CHIMP_GAME_CTRL -- requirements
Module: chimp_game_ctrl

Interface
REQ-001 SHALL have parameter START_LEVEL, default 4, meaning the count of numbers placed in round one (legal range 1..MAX_LEVEL).
REQ-002 SHALL have parameter MAX_LEVEL, default 31, meaning the level ceiling (5-bit number field).
REQ-003 SHALL have parameter MAX_STRIKES, default 3, meaning the wrong clicks that end the game.
REQ-004 SHALL have parameter SHOW_CYCLES, default 50_000_000, meaning the show timeout in clk cycles (used only under REQ-027).
REQ-005 SHALL have ports: clk  in  1  system clock; iResetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: iStart  in  1  start/restart pulse; iDoneLoad  in  1  datapath accepted current load.
REQ-007 SHALL have ports: iChoseCorrect  in  1  pulse; iChoseWrong  in  1  pulse (datapath click verdicts).
REQ-008 SHALL have ports: oRandNum  out  8  cell select {y[5:3],x[2:0]}; oLoadNum  out  5  number being placed.
REQ-009 SHALL have ports: oLoadEnable, oResetBoard, oShowEnable, oGameOver  out  1 each.
REQ-010 SHALL have ports: oChooseNum  out  5  next expected number; oLevel  out  5; oStrikes  out  2; oState  out  3  debug.

Function
REQ-011 SHALL implement states IDLE, CLEAR, LOAD, SHOW, PLAY, ROUND_WIN, STRIKE, GAME_OVER, all Moore outputs registered.
REQ-012 IDLE: all strobes low; iStart -> CLEAR with level=START_LEVEL, strikes=0.
REQ-013 CLEAR: oResetBoard high exactly one cycle; loadCount=1; -> LOAD.
REQ-014 LOAD: oLoadEnable=1, oLoadNum=loadCount, oRandNum=LFSR value; LFSR advances every cycle, so a collision (iDoneLoad low) retries a new cell next cycle.
REQ-015 LOAD on iDoneLoad: loadCount==level -> SHOW with oChooseNum=1; else loadCount+1, stay.
REQ-016 SHOW: oShowEnable=1; iChoseCorrect -> PLAY (or ROUND_WIN if level==1), oChooseNum+1; iChoseWrong -> STRIKE.
REQ-017 PLAY: oShowEnable=0; iChoseCorrect with oChooseNum==level -> ROUND_WIN, else oChooseNum+1; iChoseWrong -> STRIKE.
REQ-018 Simultaneous iChoseCorrect and iChoseWrong SHALL be treated as wrong.
REQ-019 Click pulses outside SHOW/PLAY SHALL be ignored; iStart outside IDLE/GAME_OVER SHALL be ignored.
REQ-020 ROUND_WIN (one cycle): level=min(level+1, MAX_LEVEL), saturating (no wrap); -> CLEAR.
REQ-021 STRIKE (one cycle): strikes+1; if new value==MAX_STRIKES -> GAME_OVER, else -> CLEAR at same level.
REQ-022 GAME_OVER: oGameOver=1, oLevel/oStrikes held; iStart -> CLEAR with level=START_LEVEL, strikes=0.
REQ-023 oStrikes SHALL saturate at 3.

Reset
REQ-024 iResetn low SHALL asynchronously force IDLE, all 1-bit outputs 0, oLoadNum=0, oChooseNum=0, oStrikes=0, oLevel=START_LEVEL.
REQ-025 LFSR SHALL reset to 8'hA5 (nonzero seed); reset mid-round SHALL abandon the round with no further strobes.
REQ-026 Deassertion SHALL be synchronized to clk.

Configuration
REQ-027 With CHIMP_SHOW_TIMEOUT_EN defined: SHOW also exits to PLAY after SHOW_CYCLES cycles without a click, oChooseNum unchanged (1); counter clears on SHOW entry.
REQ-028 Without CHIMP_SHOW_TIMEOUT_EN: SHOW waits indefinitely; no timeout counter synthesized.

Structure
REQ-029 Package chimp_pkg SHALL hold the state encoding, BOARD_DIM=8, NUM_W=5, LFSR seed and taps.
REQ-030 Sub-module chimp_lfsr (8-bit maximal Galois LFSR, taps x^8+x^6+x^5+x^4+1, enable input) SHALL supply oRandNum.

Verification
REQ-031 Reset, iStart; iDoneLoad high whenever oLoadEnable -> oResetBoard 1 cycle, oLoadNum 1,2,3,4, then SHOW with oChooseNum=1.
REQ-032 Level 4, correct pulses x4 -> PLAY after first, ROUND_WIN after fourth, oLevel=5, new CLEAR.
REQ-033 iDoneLoad withheld 3 cycles in LOAD -> oLoadNum stays, oRandNum changes each cycle, no skipped number.
REQ-034 Three wrong clicks across rounds -> oStrikes 1,2,3, oGameOver=1, level unchanged; iStart -> level 4, strikes 0.
REQ-035 Correct and wrong pulsed same cycle in PLAY -> STRIKE; START_LEVEL=MAX_LEVEL win -> oLevel stays 31.
REQ-036 With macro, SHOW_CYCLES=10, no clicks -> PLAY on cycle 10, oShowEnable falls; iResetn pulsed in LOAD -> IDLE immediately.

Source files
------------

// File: rtl/chimp_pkg.sv
// Shared types and constants for the chimp memory-game controller.
package chimp_pkg;

  localparam int unsigned BOARD_DIM = 8;
  localparam int unsigned NUM_W     = 5;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned LFSR_W    = 8;
  localparam int unsigned STRIKE_W  = 2;

  // Galois right-shift form of x^8+x^6+x^5+x^4+1
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_SHOW      = 3'd3,
    ST_PLAY      = 3'd4,
    ST_ROUND_WIN = 3'd5,
    ST_STRIKE    = 3'd6,
    ST_GAME_OVER = 3'd7
  } state_e;

endpackage

// File: rtl/chimp_lfsr.sv
// 8-bit maximal-length Galois LFSR used to pick board cells.
module chimp_lfsr
  import chimp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  output logic [LFSR_W-1:0] value_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/chimp_game_ctrl.sv
// Round/strike sequencer for the chimp memory game.
// Optional build macro CHIMP_SHOW_TIMEOUT_EN adds a SHOW-phase timeout.
module chimp_game_ctrl
  import chimp_pkg::*;
#(
  parameter int unsigned START_LEVEL = 4,
  parameter int unsigned MAX_LEVEL   = 31,
  parameter int unsigned MAX_STRIKES = 3,
  parameter int unsigned SHOW_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                iResetn,
  input  logic                iStart,
  input  logic                iDoneLoad,
  input  logic                iChoseCorrect,
  input  logic                iChoseWrong,
  output logic [LFSR_W-1:0]   oRandNum,
  output logic [NUM_W-1:0]    oLoadNum,
  output logic                oLoadEnable,
  output logic                oResetBoard,
  output logic                oShowEnable,
  output logic                oGameOver,
  output logic [NUM_W-1:0]    oChooseNum,
  output logic [NUM_W-1:0]    oLevel,
  output logic [STRIKE_W-1:0] oStrikes,
  output logic [STATE_W-1:0]  oState
);

  if (START_LEVEL < 1 || START_LEVEL > MAX_LEVEL || MAX_LEVEL > 31 ||
      MAX_STRIKES < 1 || MAX_STRIKES > 3 || SHOW_CYCLES < 1) begin : g_bad_param
    $error("chimp_game_ctrl: illegal parameter combination");
  end

  // Async assert, clk-synchronous release
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_e                state_q, state_d;
  logic [NUM_W-1:0]      level_q, level_d;
  logic [STRIKE_W-1:0]   strikes_q, strikes_d;
  logic [NUM_W-1:0]      load_cnt_q, load_cnt_d;
  logic [NUM_W-1:0]      choose_q, choose_d;
  logic                  load_en_q, reset_board_q, show_en_q, game_over_q;
  logic                  click_wrong, click_right;

  // A simultaneous right+wrong verdict counts as wrong
  assign click_wrong = iChoseWrong;
  assign click_right = iChoseCorrect & ~iChoseWrong;

`ifdef CHIMP_SHOW_TIMEOUT_EN
  localparam int unsigned SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  logic [SHOW_W-1:0] show_cnt_q, show_cnt_d;
  logic              show_timeout;

  assign show_timeout = (show_cnt_q == SHOW_W'(SHOW_CYCLES - 1));

  always_comb begin
    show_cnt_d = '0;
    if (state_q == ST_SHOW) show_cnt_d = show_cnt_q + SHOW_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) show_cnt_q <= '0;
    else        show_cnt_q <= show_cnt_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    strikes_d  = strikes_q;
    load_cnt_d = load_cnt_q;
    choose_d   = choose_q;
    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (iStart) begin
          state_d   = ST_CLEAR;
          level_d   = NUM_W'(START_LEVEL);
          strikes_d = '0;
        end
      end
      ST_CLEAR: begin
        load_cnt_d = NUM_W'(1);
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        if (iDoneLoad) begin
          if (load_cnt_q == level_q) begin
            state_d  = ST_SHOW;
            choose_d = NUM_W'(1);
          end else begin
            load_cnt_d = load_cnt_q + NUM_W'(1);
          end
        end
      end
      ST_SHOW: begin
        if (click_wrong) begin
          state_d = ST_STRIKE;
        end else if (click_right) begin
          choose_d = choose_q + NUM_W'(1);
          state_d  = (level_q == NUM_W'(1)) ? ST_ROUND_WIN : ST_PLAY;
        end
`ifdef CHIMP_SHOW_TIMEOUT_EN
        else if (show_timeout) begin
          state_d = ST_PLAY;
        end
`endif
      end
      ST_PLAY: begin
        if (click_wrong) begin
          state_d = ST_STRIKE;
        end else if (click_right) begin
          if (choose_q == level_q) state_d = ST_ROUND_WIN;
          else                     choose_d = choose_q + NUM_W'(1);
        end
      end
      ST_ROUND_WIN: begin
        if (level_q < NUM_W'(MAX_LEVEL)) level_d = level_q + NUM_W'(1);
        state_d = ST_CLEAR;
      end
      ST_STRIKE: begin
        if (strikes_q != '1) strikes_d = strikes_q + STRIKE_W'(1);
        if ((32'(strikes_q) + 32'd1) >= 32'(MAX_STRIKES)) state_d = ST_GAME_OVER;
        else                                               state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      level_q       <= NUM_W'(START_LEVEL);
      strikes_q     <= '0;
      load_cnt_q    <= '0;
      choose_q      <= '0;
      load_en_q     <= 1'b0;
      reset_board_q <= 1'b0;
      show_en_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      strikes_q     <= strikes_d;
      load_cnt_q    <= load_cnt_d;
      choose_q      <= choose_d;
      load_en_q     <= (state_d == ST_LOAD);
      reset_board_q <= (state_d == ST_CLEAR);
      show_en_q     <= (state_d == ST_SHOW);
      game_over_q   <= (state_d == ST_GAME_OVER);
    end
  end

  chimp_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (state_q != ST_IDLE),
    .value_o (oRandNum)
  );

  assign oLoadNum    = load_cnt_q;
  assign oLoadEnable = load_en_q;
  assign oResetBoard = reset_board_q;
  assign oShowEnable = show_en_q;
  assign oGameOver   = game_over_q;
  assign oChooseNum  = choose_q;
  assign oLevel      = level_q;
  assign oStrikes    = strikes_q;
  assign oState      = state_q;

endmodule

// File: tb/tb_chimp_game_ctrl.sv
// Directed bench for chimp_game_ctrl: vector table plus multi-cycle sequences.
module tb_chimp_game_ctrl;
  import chimp_pkg::*;

  logic clk = 1'b0;
  logic iResetn, iStart, iDoneLoad, iChoseCorrect, iChoseWrong;
  logic [7:0] oRandNum;
  logic [4:0] oLoadNum, oChooseNum, oLevel;
  logic       oLoadEnable, oResetBoard, oShowEnable, oGameOver;
  logic [1:0] oStrikes;
  logic [2:0] oState;

  logic b_start, b_done, b_cor, b_wrg;
  logic [7:0] b_rand;
  logic [4:0] b_ln, b_cn, b_lv;
  logic       b_le, b_rb, b_se, b_go;
  logic [1:0] b_sk;
  logic [2:0] b_st;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chimp_game_ctrl #(.START_LEVEL(4), .MAX_LEVEL(31), .MAX_STRIKES(3), .SHOW_CYCLES(10)) dut (
    .clk(clk), .iResetn(iResetn), .iStart(iStart), .iDoneLoad(iDoneLoad),
    .iChoseCorrect(iChoseCorrect), .iChoseWrong(iChoseWrong),
    .oRandNum(oRandNum), .oLoadNum(oLoadNum), .oLoadEnable(oLoadEnable),
    .oResetBoard(oResetBoard), .oShowEnable(oShowEnable), .oGameOver(oGameOver),
    .oChooseNum(oChooseNum), .oLevel(oLevel), .oStrikes(oStrikes), .oState(oState)
  );

  chimp_game_ctrl #(.START_LEVEL(31), .MAX_LEVEL(31), .MAX_STRIKES(3), .SHOW_CYCLES(10)) dut_max (
    .clk(clk), .iResetn(iResetn), .iStart(b_start), .iDoneLoad(b_done),
    .iChoseCorrect(b_cor), .iChoseWrong(b_wrg),
    .oRandNum(b_rand), .oLoadNum(b_ln), .oLoadEnable(b_le),
    .oResetBoard(b_rb), .oShowEnable(b_se), .oGameOver(b_go),
    .oChooseNum(b_cn), .oLevel(b_lv), .oStrikes(b_sk), .oState(b_st)
  );

  typedef struct {
    logic [3:0] in;   // {start, done, correct, wrong}
    logic [2:0] st;
    logic [4:0] ln, cn, lv;
    logic [1:0] sk;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] in, input logic [2:0] st,
                              input logic [4:0] ln, input logic [4:0] cn,
                              input logic [4:0] lv, input logic [1:0] sk);
    vec_t v;
    v.in = in; v.st = st; v.ln = ln; v.cn = cn; v.lv = lv; v.sk = sk;
    return v;
  endfunction

  function automatic logic [7:0] lfsr_nxt(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic [4:0] ln,
                         input logic [4:0] cn, input logic [4:0] lv, input logic [1:0] sk);
    chk({tag, ".state"},  32'(oState),      32'(st));
    chk({tag, ".loaden"}, 32'(oLoadEnable), 32'(st == ST_LOAD));
    chk({tag, ".rstbd"},  32'(oResetBoard), 32'(st == ST_CLEAR));
    chk({tag, ".show"},   32'(oShowEnable), 32'(st == ST_SHOW));
    chk({tag, ".gover"},  32'(oGameOver),   32'(st == ST_GAME_OVER));
    chk({tag, ".loadn"},  32'(oLoadNum),    32'(ln));
    chk({tag, ".choose"}, 32'(oChooseNum),  32'(cn));
    chk({tag, ".level"},  32'(oLevel),      32'(lv));
    chk({tag, ".strike"}, 32'(oStrikes),    32'(sk));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_until_show(input string tag);
    iDoneLoad = 1'b1;
    for (int i = 0; i < 64 && !oShowEnable; i++) tick();
    iDoneLoad = 1'b0;
    chk({tag, ".reach_show"}, 32'(oShowEnable), 32'd1);
  endtask

  vec_t vecs[13];
  logic [7:0] prev;

  initial begin
    vecs[0]  = mk(4'b1000, ST_CLEAR,     5'd0, 5'd0, 5'd4, 2'd0);
    vecs[1]  = mk(4'b0000, ST_LOAD,      5'd1, 5'd0, 5'd4, 2'd0);
    vecs[2]  = mk(4'b0100, ST_LOAD,      5'd2, 5'd0, 5'd4, 2'd0);
    vecs[3]  = mk(4'b0100, ST_LOAD,      5'd3, 5'd0, 5'd4, 2'd0);
    vecs[4]  = mk(4'b0100, ST_LOAD,      5'd4, 5'd0, 5'd4, 2'd0);
    vecs[5]  = mk(4'b0100, ST_SHOW,      5'd4, 5'd1, 5'd4, 2'd0);
    vecs[6]  = mk(4'b0010, ST_PLAY,      5'd4, 5'd2, 5'd4, 2'd0);
    vecs[7]  = mk(4'b0010, ST_PLAY,      5'd4, 5'd3, 5'd4, 2'd0);
    vecs[8]  = mk(4'b0000, ST_PLAY,      5'd4, 5'd3, 5'd4, 2'd0);
    vecs[9]  = mk(4'b0010, ST_PLAY,      5'd4, 5'd4, 5'd4, 2'd0);
    vecs[10] = mk(4'b0010, ST_ROUND_WIN, 5'd4, 5'd4, 5'd4, 2'd0);
    vecs[11] = mk(4'b0000, ST_CLEAR,     5'd4, 5'd4, 5'd5, 2'd0);
    vecs[12] = mk(4'b0000, ST_LOAD,      5'd1, 5'd4, 5'd5, 2'd0);

    iResetn = 1'b0;
    {iStart, iDoneLoad, iChoseCorrect, iChoseWrong} = 4'b0000;
    {b_start, b_done, b_cor, b_wrg} = 4'b0000;
    tick(); tick();
    chk_out("reset", ST_IDLE, 5'd0, 5'd0, 5'd4, 2'd0);
    chk("reset.rand", 32'(oRandNum), 32'h0000_00A5);
    iResetn = 1'b1;
    tick(); tick(); tick();
    chk_out("idle", ST_IDLE, 5'd0, 5'd0, 5'd4, 2'd0);

    for (int i = 0; i < 13; i++) begin
      {iStart, iDoneLoad, iChoseCorrect, iChoseWrong} = vecs[i].in;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].ln, vecs[i].cn, vecs[i].lv, vecs[i].sk);
    end
    {iStart, iDoneLoad, iChoseCorrect, iChoseWrong} = 4'b0000;

    // Load withheld: number holds, cell keeps moving; stray start/clicks ignored
    prev = oRandNum;
    for (int i = 0; i < 3; i++) begin
      {iStart, iChoseCorrect, iChoseWrong} = (i == 1) ? 3'b111 : 3'b000;
      tick();
      chk_out($sformatf("hold%0d", i), ST_LOAD, 5'd1, 5'd4, 5'd5, 2'd0);
      chk($sformatf("hold%0d.rand_step", i), 32'(oRandNum), 32'(lfsr_nxt(prev)));
      chk($sformatf("hold%0d.rand_moved", i), 32'(oRandNum != prev), 32'd1);
      prev = oRandNum;
    end
    {iStart, iChoseCorrect, iChoseWrong} = 3'b000;
    load_until_show("r2");
    chk_out("r2show", ST_SHOW, 5'd5, 5'd1, 5'd5, 2'd0);

    // Strike 1: wrong in SHOW
    iChoseWrong = 1'b1; tick(); iChoseWrong = 1'b0;
    chk_out("s1", ST_STRIKE, 5'd5, 5'd1, 5'd5, 2'd0);
    tick();
    chk_out("s1clr", ST_CLEAR, 5'd5, 5'd1, 5'd5, 2'd1);
    tick();
    load_until_show("r3");

    // Strike 2: correct+wrong together in PLAY
    iChoseCorrect = 1'b1; tick();
    chk_out("r3play", ST_PLAY, 5'd5, 5'd2, 5'd5, 2'd1);
    iChoseWrong = 1'b1; tick(); {iChoseCorrect, iChoseWrong} = 2'b00;
    chk_out("both", ST_STRIKE, 5'd5, 5'd2, 5'd5, 2'd1);
    tick();
    chk_out("s2clr", ST_CLEAR, 5'd5, 5'd2, 5'd5, 2'd2);
    tick();
    load_until_show("r4");

    // Strike 3 ends the game
    iChoseWrong = 1'b1; tick(); iChoseWrong = 1'b0;
    chk_out("s3", ST_STRIKE, 5'd5, 5'd1, 5'd5, 2'd2);
    tick();
    chk_out("gover", ST_GAME_OVER, 5'd5, 5'd1, 5'd5, 2'd3);
    {iDoneLoad, iChoseCorrect} = 2'b11; tick(); {iDoneLoad, iChoseCorrect} = 2'b00;
    chk_out("gohold", ST_GAME_OVER, 5'd5, 5'd1, 5'd5, 2'd3);
    iStart = 1'b1; tick(); iStart = 1'b0;
    chk_out("restart", ST_CLEAR, 5'd5, 5'd1, 5'd4, 2'd0);
    tick();
    load_until_show("r5");
    chk_out("r5show", ST_SHOW, 5'd4, 5'd1, 5'd4, 2'd0);

`ifdef CHIMP_SHOW_TIMEOUT_EN
    for (int i = 1; i < 10; i++) tick();
    chk_out("to_last", ST_SHOW, 5'd4, 5'd1, 5'd4, 2'd0);
    tick();
    chk_out("to_play", ST_PLAY, 5'd4, 5'd1, 5'd4, 2'd0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk_out("no_to", ST_SHOW, 5'd4, 5'd1, 5'd4, 2'd0);
`endif
    iChoseCorrect = 1'b1; tick(); iChoseCorrect = 1'b0;
    chk_out("r5play", ST_PLAY, 5'd4, 5'd2, 5'd4, 2'd0);

    // Reset mid-round: immediate IDLE, no strobes afterwards
    iChoseWrong = 1'b1; tick(); iChoseWrong = 1'b0;
    tick(); tick();
    chk_out("preRst", ST_LOAD, 5'd1, 5'd2, 5'd4, 2'd1);
    iDoneLoad = 1'b1;
    iResetn = 1'b0;
    #1;
    chk_out("arst", ST_IDLE, 5'd0, 5'd0, 5'd4, 2'd0);
    tick(); tick();
    chk_out("arst_hold", ST_IDLE, 5'd0, 5'd0, 5'd4, 2'd0);
    iDoneLoad = 1'b0;
    iResetn = 1'b1;
    tick(); tick(); tick();
    chk_out("post_rst", ST_IDLE, 5'd0, 5'd0, 5'd4, 2'd0);
    chk("post_rst.rand", 32'(oRandNum), 32'h0000_00A5);

    // Level saturation on a START_LEVEL==MAX_LEVEL instance
    b_start = 1'b1; tick(); b_start = 1'b0;
    {b_done, b_cor} = 2'b11;
    for (int i = 0; i < 200 && b_st != 3'(ST_ROUND_WIN); i++) tick();
    chk("sat.rw_state", 32'(b_st), 32'(ST_ROUND_WIN));
    chk("sat.rw_choose", 32'(b_cn), 32'd31);
    tick();
    {b_done, b_cor} = 2'b00;
    chk("sat.clr_state", 32'(b_st), 32'(ST_CLEAR));
    chk("sat.level", 32'(b_lv), 32'd31);
    chk("sat.rstbd", 32'(b_rb), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
